// File: rtl/vga_pkg.sv
// Shared video-path definitions: default address/pixel widths and the VRAM grant encoding.
package vga_pkg;

  localparam int unsigned ROW_W = 9;
  localparam int unsigned COL_W = 10;
  localparam int unsigned PIX_W = 12;

  // Owner of the single RAM port for the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, parameterised width and power-of-two depth.
// Ports: clk_i/rst_i (sync, active-high), push_i/wdata_i write side,
// pop_i/rdata_o read side (rdata_o shows the head, first-word fall-through),
// full_o/empty_o status, level_o occupancy count.
module sync_fifo #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Depth  = 4,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned LevelW = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [Width-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o
);

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller ignores status.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers wrap naturally because Depth is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LevelW'(1);
      2'b01:   level_d = level_q - LevelW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; resetting the pointers discards its contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port, 1-cycle-latency video RAM between VGA scan-out reads and buffered
// host pixel writes. The display always wins; host writes wait in a FIFO and drain on cycles
// where rdn is high.
// Ports: clk/rst (sync, active-high); rdn/row_addr/col_addr display read request;
// pix_data/pix_valid registered pixel out (2 cycles after the request);
// wr_valid/wr_ready/wr_addr/wr_data host write handshake; fifo_level buffered count;
// mem_en/mem_we/mem_addr/mem_wdata/mem_rdata RAM port.
module vram_arbiter #(
  parameter int unsigned ROW_W      = vga_pkg::ROW_W,
  parameter int unsigned COL_W      = vga_pkg::COL_W,
  parameter int unsigned PIX_W      = vga_pkg::PIX_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdn,
  input  logic [ROW_W-1:0]               row_addr,
  input  logic [COL_W-1:0]               col_addr,
  output logic [PIX_W-1:0]               pix_data,
  output logic                           pix_valid,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ROW_W+COL_W-1:0]         wr_addr,
  input  logic [PIX_W-1:0]               wr_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ROW_W+COL_W-1:0]         mem_addr,
  output logic [PIX_W-1:0]               mem_wdata,
  input  logic [PIX_W-1:0]               mem_rdata
);

  import vga_pkg::*;

  localparam int unsigned AddrW = ROW_W + COL_W;
  localparam int unsigned EntW  = AddrW + PIX_W;

  gnt_e             gnt;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EntW-1:0]  fifo_head;

  logic             rd_pend_q, rd_pend_d;
  logic             pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;

  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && wr_ready;
  assign fifo_pop  = (gnt == GNT_HOST);

  sync_fifo #(
    .Width (EntW),
    .Depth (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i ({wr_addr, wr_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Grant is forced idle during reset so buffered writes are dropped without touching the RAM.
  always_comb begin
    gnt = GNT_IDLE;
    if (rst) begin
      gnt = GNT_IDLE;
    end else if (!rdn) begin
      gnt = GNT_DISP;
    end else if (!fifo_empty) begin
      gnt = GNT_HOST;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt)
      GNT_DISP: begin
        mem_en   = 1'b1;
        mem_addr = {row_addr, col_addr};
      end
      GNT_HOST: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_head[EntW-1:PIX_W];
        mem_wdata = fifo_head[PIX_W-1:0];
      end
      default: ;
    endcase
  end

  // Two-stage read pipeline: rd_pend marks the cycle mem_rdata is valid; the pixel register
  // then holds it for one cycle. Non-read slots produce a blanked (zero) pixel.
  always_comb begin
    rd_pend_d   = (gnt == GNT_DISP);
    pix_valid_d = rd_pend_q;
    pix_data_d  = rd_pend_q ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: the stimulus side queues expected RAM writes and pixels;
// a negedge monitor pops and compares whenever the DUT presents a write or a valid pixel.
module tb_vram_arbiter;

  localparam int unsigned RW = 9;
  localparam int unsigned CW = 10;
  localparam int unsigned PW = 12;
  localparam int unsigned AW = RW + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdn = 1'b1;
  logic [RW-1:0] row_addr = '0;
  logic [CW-1:0] col_addr = '0;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [PW-1:0] wr_data = '0;
  logic [2:0]    fifo_level;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_wdata;
  logic [PW-1:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [PW-1:0]    ram [0:(1<<AW)-1];
  logic [AW+PW-1:0] exp_wr [$];
  logic [PW-1:0]    exp_pix [$];
  logic [1:0]       hist = 2'b00;

  vram_arbiter #(
    .ROW_W      (RW),
    .COL_W      (CW),
    .PIX_W      (PW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdn        (rdn),
    .row_addr   (row_addr),
    .col_addr   (col_addr),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fifo_level (fifo_level),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM model, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the queued expectations, then records this
  // cycle's stimulus (accepted writes, display reads) as new expectations.
  always @(negedge clk) begin
    if (rst) begin
      hist = 2'b00;
      exp_pix.delete();
      exp_wr.delete();
    end else if (chk_en) begin
      chk("pix_valid", 32'(pix_valid), 32'(hist[1]));
      if (hist[1]) begin
        if (exp_pix.size() == 0) chk("pix_queue_empty", 32'(pix_data), 32'hFFFF_FFFF);
        else chk("pix_data", 32'(pix_data), 32'(exp_pix.pop_front()));
      end else begin
        chk("pix_blank", 32'(pix_data), 32'd0);
      end
      if (mem_en && mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("wr_queue_empty", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          logic [AW+PW-1:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[AW+PW-1:PW]));
          chk("wr_data", 32'(mem_wdata), 32'(e[PW-1:0]));
        end
      end else if (!mem_en) begin
        chk("idle_addr", 32'({mem_addr, mem_wdata}), 32'd0);
      end
      if (wr_valid && wr_ready) exp_wr.push_back({wr_addr, wr_data});
      if (!rdn) exp_pix.push_back(ram[{row_addr, col_addr}]);
      hist = {hist[0], !rdn};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) ram[a] = '0;
    ram[{9'd5, 10'd17}] = 12'hABC;
    for (int i = 0; i < 10; i++) ram[{RW'(i + 20), CW'(3 * i)}] = PW'(12'h500 + i);

    // Power-on reset
    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);

    // Display latency: address in cycle N, pixel at N+2
    step();
    rdn = 1'b0; row_addr = 9'd5; col_addr = 10'd17;
    @(negedge clk);
    chk("disp_addr", 32'(mem_addr), 32'({9'd5, 10'd17}));
    chk("disp_en_we", 32'({mem_en, mem_we}), 32'b10);
    step();
    rdn = 1'b1;
    step();
    @(negedge clk);
    chk("lat_valid", 32'(pix_valid), 32'd1);
    chk("lat_data", 32'(pix_data), 32'hABC);

    // Priority: one buffered write held off by 8 display cycles
    step();
    rdn = 1'b0; row_addr = 9'd7; col_addr = 10'd7;
    wr_valid = 1'b1; wr_addr = 19'h100; wr_data = 12'h0F0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("prio_no_we", 32'(mem_we), 32'd0);
      step();
      wr_valid = 1'b0;
    end
    rdn = 1'b1;
    @(negedge clk);
    chk("prio_we", 32'(mem_we), 32'd1);
    chk("prio_addr", 32'(mem_addr), 32'h100);
    chk("prio_data", 32'(mem_wdata), 32'h0F0);

    // Full: 5 pushes under display, 4 accepted, then in-order drain
    for (int i = 0; i < 5; i++) begin
      step();
      rdn = 1'b0;
      wr_valid = 1'b1; wr_addr = AW'(19'h200 + i); wr_data = PW'(12'h100 + i);
      @(negedge clk);
      chk("full_ready", 32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    step();
    wr_valid = 1'b0; rdn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_we", 32'(mem_we), 32'd1);
      chk("drain_addr", 32'(mem_addr), 32'(19'h200 + k));
      step();
    end
    @(negedge clk);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_idle", 32'(mem_en), 32'd0);

    // Simultaneous push/pop at level 2
    for (int i = 0; i < 8; i++) begin
      step();
      rdn = (i < 2) ? 1'b0 : 1'b1;
      wr_valid = 1'b1; wr_addr = AW'(19'h300 + i); wr_data = PW'(12'h700 + i);
      @(negedge clk);
      if (i >= 2) chk("simul_level", 32'(fifo_level), 32'd2);
    end
    step();
    wr_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("simul_empty", 32'(fifo_level), 32'd0);

    // Blanking: irregular rdn pattern, monitor checks the 2-cycle shadow
    for (int i = 0; i < 10; i++) begin
      step();
      rdn = ((10'b0101100100 >> i) & 1) == 0;
      row_addr = RW'(i + 20); col_addr = CW'(3 * i);
    end
    step();
    rdn = 1'b1;
    repeat (3) step();

    // Reset mid-burst with 3 buffered writes and rdn high
    for (int i = 0; i < 3; i++) begin
      step();
      rdn = 1'b0;
      wr_valid = 1'b1; wr_addr = AW'(19'h400 + i); wr_data = PW'(12'h0A0 + i);
    end
    step();
    wr_valid = 1'b0; rdn = 1'b1; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstb_no_we", 32'(mem_we), 32'd0);
      if (k == 0) chk("rstb_level_before", 32'(fifo_level), 32'd3);
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstb_level", 32'(fifo_level), 32'd0);
      chk("rstb_pix_valid", 32'(pix_valid), 32'd0);
      chk("rstb_wr_ready", 32'(wr_ready), 32'd1);
      chk("rstb_no_we_after", 32'(mem_we), 32'd0);
      step();
    end

    @(negedge clk);
    chk("sb_wr_left", 32'(exp_wr.size()), 32'd0);
    chk("sb_pix_left", 32'(exp_pix.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, 1-cycle-latency video RAM between two requesters: VGA scan-out reads and host pixel writes.
- The display always has priority. Host writes are absorbed into a small FIFO and drained into the RAM on cycles when the display is not reading.
- Sits between the VGA timing controller (row/col address, active-low read strobe) and the block-RAM pixel store, all on the divided pixel clock.

Parameters:
- ROW_W, 9, row address width from the VGA controller
- COL_W, 10, column address width from the VGA controller
- PIX_W, 12, pixel width (4R 4G 4B)
- FIFO_DEPTH, 4, host write buffer entries (power of two, at least 2)

Ports:
- clk  in  1  pixel clock (divided clock)
- rst  in  1  synchronous, active-high reset
- rdn  in  1  display read request, active low, asserted during visible area
- row_addr  in  ROW_W  display row
- col_addr  in  COL_W  display column
- pix_data  out  PIX_W  registered pixel to the VGA r/g/b inputs
- pix_valid  out  1  pix_data holds a fetched pixel
- wr_valid  in  1  host write request
- wr_ready  out  1  FIFO can accept a host write
- wr_addr  in  ROW_W+COL_W  host pixel address, {row,col}
- wr_data  in  PIX_W  host pixel value
- fifo_level  out  $clog2(FIFO_DEPTH)+1  buffered write count
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ROW_W+COL_W  RAM address
- mem_wdata  out  PIX_W  RAM write data
- mem_rdata  in  PIX_W  RAM read data, valid 1 cycle after a read cycle

Behaviour:
- Reset: synchronous and active-high. Only rst at a clk edge clears state.
  - Reset values: pix_data=0, pix_valid=0, fifo_level=0, FIFO pointers=0, read pipeline flags=0.
  - wr_ready=1 in the cycle after reset.
  - Pending buffered writes are discarded; there is no partial RAM write.
- Arbitration is combinational each cycle. Memory outputs are driven combinationally from the grant.
  - Grant rule: if rdn==0, DISPLAY. Else if FIFO not empty, HOST. Else IDLE.
  - DISPLAY: mem_en=1, mem_we=0, mem_addr={row_addr,col_addr}.
  - HOST: mem_en=1, mem_we=1, addr/data taken from the FIFO head. The FIFO pops at the clk edge.
  - IDLE: mem_en=0, mem_we=0, mem_addr and mem_wdata hold 0.
- Display latency: 2 cycles from rdn low to pix_data/pix_valid.
  - Cycle N: address presented.
  - N+1: mem_rdata valid; rd_pend flag set.
  - N+2: pix_data=mem_rdata, pix_valid=1.
  - For any cycle whose read flag is 0, pix_data=0 and pix_valid=0. This blanks the output during blanking and host-write slots.
- Host handshake (valid/ready):
  - A write is accepted on an edge where wr_valid && wr_ready.
  - wr_ready = !full, derived from the registered count. There is no same-cycle bypass.
  - Accepted data is never dropped except by reset.
- FIFO corner cases:
  - Push and pop in the same cycle: level unchanged.
  - Full: wr_ready=0. A pop that cycle frees a slot visible next cycle.
  - Empty with wr_valid: the entry is written on the next HOST grant, no earlier than 1 cycle after acceptance.
  - Pointers wrap modulo FIFO_DEPTH.
- Write ordering is preserved.
- Read/write hazard: a host write to the pixel currently being displayed is not forwarded. The display shows old or new data depending on grant order.
- Starvation: host writes stall for the whole visible line. This is accepted by design; hosts use wr_ready.

Decomposition:
- Shared package vga_pkg holds ROW_W, COL_W, PIX_W and the grant encoding (GNT_IDLE, GNT_DISP, GNT_HOST).
- One sub-module: sync_fifo (parameterised width/depth), with push/pop/full/empty/level. It is reused elsewhere in the video path.
- The arbiter and read pipeline stay in vram_arbiter.

Test Plan:
- Reset check: assert rst for 3 cycles mid-write-burst with FIFO holding 3 entries, rdn=1 → afterwards fifo_level=0, pix_valid=0, wr_ready=1, and no mem_we pulse.
- Display latency: rdn=0, row=5, col=17, RAM model returns 0xABC → mem_addr={9'd5,10'd17} in cycle N, pix_data=0xABC and pix_valid=1 at N+2.
- Priority: FIFO holds 1 write (addr 0x100, data 0x0F0), rdn=0 for 8 cycles → mem_we stays 0. On the first cycle with rdn=1, mem_we=1 with addr 0x100 and data 0x0F0.
- Full: rdn=0 held, push 5 writes back-to-back → 4 accepted, wr_ready=0 on the 5th. Releasing rdn drains them in order over 4 cycles.
- Simultaneous events: rdn=1, FIFO level 2, push each cycle → level stays 2 and RAM write order matches push order.
- Blanking: toggle rdn 0/1/0 → pix_valid follows with exactly 2-cycle delay and pix_data=0 whenever pix_valid=0.
